// File: rtl/dmem_responder.sv
// Byte-addressed data memory with a fixed-latency read responder.
// Writes commit in a single cycle; each read returns one word through a one-cycle response strobe.
module dmem_responder #(
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   dmem_wr_en_in,
    input  logic                         dmem_rd_en_in,
    input  logic [31:0]                  dmem_addr_in,
    input  logic [31:0]                  dmem_data_in,
    output logic                         dmem_valid_out,
    output logic [$clog2(MEM_DEPTH)-1:0] dmem_valid_addr_out,
    output logic [31:0]                  dmem_data_out
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [7:0]    mem_r [MEM_DEPTH];
    logic [AW-1:0] req_idx_s;
    logic [AW-1:0] lat_addr_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   rd_word_s;
    logic          accept_s;
    logic          capture_s;
    logic          valid_r;
    logic [AW-1:0] resp_addr_r;
    logic [31:0]   resp_data_r;
    logic          addr_hi_unused_s;

    // Address bits above the memory size wrap onto the array and carry no meaning.
    assign req_idx_s        = dmem_addr_in[AW-1:0];
    assign addr_hi_unused_s = ^dmem_addr_in[31:AW];

    // Little-endian word gathered from the latched address, wrapping at the top of the array.
    assign rd_word_s = {mem_r[lat_addr_r + AW'(3)], mem_r[lat_addr_r + AW'(2)],
                        mem_r[lat_addr_r + AW'(1)], mem_r[lat_addr_r]};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; read requests are only looked at while idle.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dmem_rd_en_in) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == {CW{1'b0}}) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Latency counter and latched request address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {CW{1'b0}};
            lat_addr_r <= {AW{1'b0}};
        end else if (accept_s) begin
            cnt_r      <= CNT_LOAD;
            lat_addr_r <= req_idx_s;
        end else if ((state_r == ST_BUSY) && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CW'(1);
        end
    end

    // Response registers: strobe for one cycle, address and data held until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r     <= 1'b0;
            resp_addr_r <= {AW{1'b0}};
            resp_data_r <= 32'h0000_0000;
        end else begin
            valid_r <= capture_s;
            if (capture_s) begin
                resp_addr_r <= lat_addr_r;
                resp_data_r <= rd_word_s;
            end
        end
    end

    // Byte-lane writes; the capture above reads the array before these commit on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (dmem_wr_en_in[k]) begin
                    mem_r[req_idx_s + AW'(k)] <= dmem_data_in[8*k +: 8];
                end
            end
        end
    end

    assign dmem_valid_out      = valid_r;
    assign dmem_valid_addr_out = resp_addr_r;
    assign dmem_data_out       = resp_data_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, hand-written multi-cycle sequences,
// then randomized traffic checked against a scheduling reference model.
module tb_dmem_responder;

    localparam int DEPTH = 4096;
    localparam int RL    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wr_en = 4'b0000;
    logic        rd_en = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        valid;
    logic [11:0] vaddr;
    logic [31:0] rdata;

    int n_vec = 0;
    int n_err = 0;

    dmem_responder #(.MEM_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dmem_wr_en_in       (wr_en),
        .dmem_rd_en_in       (rd_en),
        .dmem_addr_in        (addr),
        .dmem_data_in        (wdata),
        .dmem_valid_out      (valid),
        .dmem_valid_addr_out (vaddr),
        .dmem_data_out       (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wr;
        logic        rd;
        logic [31:0] a;
        logic [31:0] d;
        logic        ev;
        logic [11:0] ea;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[28];

    // reference model state: memory image plus read scheduling by edge number
    logic [7:0]  mm [DEPTH];
    int          edge_n;
    int          cap_edge;
    int          next_free;
    bit          pending;
    int          lat;
    logic        m_valid;
    logic [11:0] m_addr;
    logic [31:0] m_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] w, input logic r, input logic [31:0] a, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
    endtask

    // Advance the model by one rising edge carrying the given inputs.
    task automatic model_edge(input logic [3:0] w, input logic r, input logic [31:0] a, input logic [31:0] d);
        m_valid = 1'b0;
        if (pending && edge_n == cap_edge) begin
            m_data    = {mm[(lat + 3) % DEPTH], mm[(lat + 2) % DEPTH], mm[(lat + 1) % DEPTH], mm[lat]};
            m_addr    = 12'(lat);
            m_valid   = 1'b1;
            pending   = 1'b0;
            next_free = edge_n + 2;
        end else if (!pending && edge_n >= next_free && r) begin
            pending  = 1'b1;
            cap_edge = edge_n + RL;
            lat      = int'(a % DEPTH);
        end
        for (int k = 0; k < 4; k++) begin
            if (w[k]) mm[(int'(a % DEPTH) + k) % DEPTH] = d[8*k +: 8];
        end
        edge_n++;
    endtask

    task automatic rstep(input logic [3:0] w, input logic r, input logic [31:0] a, input logic [31:0] d);
        drive(w, r, a, d);
        model_edge(w, r, a, d);
        tick();
        chk("rnd_valid", {31'b0, valid}, {31'b0, m_valid});
        chk("rnd_addr", {20'b0, vaddr}, {20'b0, m_addr});
        chk("rnd_data", rdata, m_data);
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 12'h000, 32'h0000_0000};
        tbl[1]  = '{4'b0000, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0, 12'h000, 32'h0000_0000};
        tbl[2]  = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h000, 32'h0000_0000};
        tbl[3]  = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 12'h010, 32'hDEAD_BEEF};
        tbl[4]  = '{4'b0001, 1'b0, 32'h0000_0011, 32'h0000_0055, 1'b0, 12'h010, 32'hDEAD_BEEF};
        tbl[5]  = '{4'b0011, 1'b0, 32'h0000_0012, 32'h0000_AA77, 1'b0, 12'h010, 32'hDEAD_BEEF};
        tbl[6]  = '{4'b0001, 1'b0, 32'h0000_0014, 32'h0000_0099, 1'b0, 12'h010, 32'hDEAD_BEEF};
        tbl[7]  = '{4'b0000, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0, 12'h010, 32'hDEAD_BEEF};
        tbl[8]  = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h010, 32'hDEAD_BEEF};
        tbl[9]  = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 12'h010, 32'hAA77_55EF};
        tbl[10] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h010, 32'hAA77_55EF};
        tbl[11] = '{4'b0000, 1'b1, 32'h0000_0011, 32'h0000_0000, 1'b0, 12'h010, 32'hAA77_55EF};
        tbl[12] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h010, 32'hAA77_55EF};
        tbl[13] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 12'h011, 32'h99AA_7755};
        tbl[14] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h011, 32'h99AA_7755};
        tbl[15] = '{4'b1111, 1'b0, 32'h0000_0FFE, 32'h4433_2211, 1'b0, 12'h011, 32'h99AA_7755};
        tbl[16] = '{4'b0000, 1'b1, 32'h0000_1FFE, 32'h0000_0000, 1'b0, 12'h011, 32'h99AA_7755};
        tbl[17] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h011, 32'h99AA_7755};
        tbl[18] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 12'hFFE, 32'h4433_2211};
        tbl[19] = '{4'b1100, 1'b0, 32'h0000_0000, 32'hCCBB_0000, 1'b0, 12'hFFE, 32'h4433_2211};
        tbl[20] = '{4'b0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'hFFE, 32'h4433_2211};
        tbl[21] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'hFFE, 32'h4433_2211};
        tbl[22] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 12'h000, 32'hCCBB_4433};
        tbl[23] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h000, 32'hCCBB_4433};
        tbl[24] = '{4'b1111, 1'b1, 32'hABC0_0050, 32'h1357_9BDF, 1'b0, 12'h000, 32'hCCBB_4433};
        tbl[25] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h000, 32'hCCBB_4433};
        tbl[26] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 12'h050, 32'h1357_9BDF};
        tbl[27] = '{4'b0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h050, 32'h1357_9BDF};

        // reset state
        rst = 1'b1;
        repeat (2) tick();
        chk("reset_valid", {31'b0, valid}, 32'h0);
        chk("reset_addr", {20'b0, vaddr}, 32'h0);
        chk("reset_data", rdata, 32'h0);
        rst = 1'b0;
        tick();

        // directed vectors: word, byte/halfword, wrap-around, same-cycle write and read
        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
            tick();
            chk($sformatf("tbl%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_addr", i), {20'b0, vaddr}, {20'b0, tbl[i].ea});
            chk($sformatf("tbl%0d_data", i), rdata, tbl[i].ed);
        end

        // held request for six edges: accepted at relative edges 0 and 4
        drive(4'b1111, 1'b0, 32'h20, 32'h0BAD_F00D);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(4'b0000, (i < 6), 32'h20, 32'h0);
            tick();
            chk($sformatf("held%0d_valid", i), {31'b0, valid}, {31'b0, (i == 2 || i == 6)});
            if (i == 2 || i == 6) chk($sformatf("held%0d_data", i), rdata, 32'h0BAD_F00D);
        end

        // asynchronous reset in the middle of a read
        drive(4'b1111, 1'b0, 32'h30, 32'h5A5A_1234);
        tick();
        drive(4'b0000, 1'b1, 32'h30, 32'h0);
        tick();
        rd_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, valid}, 32'h0);
        chk("arst_addr", {20'b0, vaddr}, 32'h0);
        chk("arst_data", rdata, 32'h0);
        drive(4'b1111, 1'b0, 32'h30, 32'hFFFF_FFFF);
        repeat (2) tick();
        chk("rst_hold_data", rdata, 32'h0);
        drive(4'b0000, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", i), {31'b0, valid}, 32'h0);
        end
        drive(4'b0000, 1'b1, 32'h30, 32'h0);
        tick();
        drive(4'b0000, 1'b0, 32'h0, 32'h0);
        repeat (2) tick();
        chk("post_rst_rd_valid", {31'b0, valid}, 32'h1);
        chk("post_rst_rd_addr", {20'b0, vaddr}, 32'h30);
        chk("post_rst_rd_data", rdata, 32'h5A5A_1234);
        tick();

        // write landing on the capture edge is not seen by that read
        drive(4'b1111, 1'b0, 32'h40, 32'h1111_1111);
        tick();
        drive(4'b0000, 1'b1, 32'h40, 32'h0);
        tick();
        drive(4'b0000, 1'b0, 32'h0, 32'h0);
        tick();
        drive(4'b1111, 1'b0, 32'h40, 32'h2222_2222);
        tick();
        chk("cap_edge_valid", {31'b0, valid}, 32'h1);
        chk("cap_edge_data", rdata, 32'h1111_1111);
        drive(4'b0000, 1'b0, 32'h0, 32'h0);
        tick();
        drive(4'b0000, 1'b1, 32'h40, 32'h0);
        tick();
        drive(4'b0000, 1'b0, 32'h0, 32'h0);
        repeat (2) tick();
        chk("cap_next_valid", {31'b0, valid}, 32'h1);
        chk("cap_next_data", rdata, 32'h2222_2222);
        tick();

        // randomized traffic against the model, starting from a known idle state
        edge_n    = 0;
        next_free = 0;
        pending   = 1'b0;
        lat       = 0;
        m_valid   = 1'b0;
        m_addr    = 12'h040;
        m_data    = 32'h2222_2222;
        for (int b = 0; b < 20; b++) rstep(4'b1111, 1'b0, 32'(4 * b), $urandom);
        for (int b = 0; b < 16; b++) rstep(4'b1111, 1'b0, 32'(12'hFC0 + 4 * b), $urandom);
        for (int i = 0; i < 3000; i++) begin
            int          sel;
            logic [31:0] ra;
            logic [3:0]  rw;
            sel = int'($urandom_range(0, 127));
            ra  = {$urandom, 12'h000} | ((sel < 64) ? 32'(sel) : 32'(12'hFC0 + sel - 64));
            rw  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            rstep(rw, ($urandom_range(0, 2) != 0), ra, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
